// File: rtl/cheshire_cfg_seq_pkg.sv
// Shared types and helpers for the Cheshire configuration sequencer.
package cheshire_cfg_seq_pkg;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    LATCH   = 3'd1,
    STAGGER = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4
  } seq_state_e;

  localparam int unsigned DefaultStableCycles  = 8;
  localparam int unsigned DefaultStaggerCycles = 16;

  // Upper bounds for the mask helper; NumCfgs*NumCores must fit in MaxMaskW.
  localparam int unsigned MaxCores = 16;
  localparam int unsigned MaxMaskW = 256;

  // Extract the per-config core mask for config idx from the flat vector.
  function automatic logic [MaxCores-1:0] cfg_mask_slice(
    input logic [MaxMaskW-1:0] mask_vec,
    input int unsigned         idx,
    input int unsigned         ncores
  );
    logic [MaxMaskW-1:0] sh;
    sh = mask_vec >> (idx * ncores);
    return sh[MaxCores-1:0];
  endfunction

endpackage

// File: rtl/cheshire_cfg_seq_filter.sv
// Config-pin synchronizer plus stability filter.
// Counts consecutive equal synchronized samples while en_i is high; once the
// count reaches StableCycles the sample and count freeze so idx_o holds the
// filtered value until clr_i drops the count back to zero.
module cheshire_cfg_seq_filter #(
  parameter int unsigned CfgIdxW      = 3,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned StableCycles = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [CfgIdxW-1:0] idx_i,
  input  logic               en_i,
  input  logic               clr_i,
  output logic               stable_o,
  output logic [CfgIdxW-1:0] idx_o
);

  localparam int unsigned CntW = $clog2(StableCycles + 1);

  logic [SyncStages-1:0][CfgIdxW-1:0] sync_d, sync_q;
  logic [CfgIdxW-1:0]                 prev_d, prev_q, samp;
  logic [CntW-1:0]                    cnt_d, cnt_q;

  assign samp     = sync_q[SyncStages-1];
  assign stable_o = (cnt_q == CntW'(StableCycles));
  assign idx_o    = prev_q;

  // Shift the pins through the synchronizer and track run length of equal samples.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], idx_i};
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !stable_o) begin
      prev_d = samp;
      cnt_d  = (samp == prev_q) ? cnt_q + 1'b1 : CntW'(1);
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cheshire_cfg_sequencer.sv
// Cheshire configuration sequencer: filters the config-select pins after
// reset, latches the effective config and releases per-core resets in a
// staggered order given by that config's core mask. A handshaked restart
// drains all cores and re-samples the pins.
// Optional restart lock: define CHESHIRE_CFG_SEQ_LOCK_EN.
// Latency: with a non-zero pin value held from reset, core 0 (if enabled)
// leaves reset SyncStages+StableCycles+2+StaggerCycles cycles after rst_ni
// deassertion (28 with defaults). Index 0 equals the synchronizer reset value,
// so it filters SyncStages cycles sooner.
module cheshire_cfg_sequencer
  import cheshire_cfg_seq_pkg::*;
#(
  parameter  int unsigned NumCfgs       = 5,
  parameter  int unsigned NumCores      = 4,
  parameter  int unsigned SyncStages    = 2,
  parameter  int unsigned StableCycles  = DefaultStableCycles,
  parameter  int unsigned StaggerCycles = DefaultStaggerCycles,
  parameter  int unsigned DefaultIdx    = 0,
  localparam int unsigned CfgIdxW       = $clog2(NumCfgs)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [CfgIdxW-1:0]          cfg_idx_i,
  input  logic [NumCfgs*NumCores-1:0] cfg_core_mask_i,
  input  logic                        restart_req_i,
  output logic                        restart_ack_o,
  input  logic                        lock_i,
  output logic [CfgIdxW-1:0]          cfg_idx_o,
  output logic                        cfg_valid_o,
  output logic                        cfg_err_o,
  output logic [NumCores-1:0]         core_rst_no,
  output logic                        done_o
);

  localparam int unsigned PtrW = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned TmrW = $clog2(StaggerCycles + 1);

  seq_state_e           state_d, state_q;
  logic [PtrW-1:0]      ptr_d, ptr_q;
  logic [TmrW-1:0]      tmr_d, tmr_q;
  logic [NumCores-1:0]  mask_d, mask_q;
  logic [NumCores-1:0]  rel_d, rel_q;
  logic [CfgIdxW-1:0]   idx_d, idx_q;
  logic                 err_d, err_q;
  logic                 filt_stable, filt_oor, locked;
  logic [CfgIdxW-1:0]   filt_idx, idx_eff;
  logic [MaxMaskW-1:0]  mask_ext;
  logic [MaxCores-1:0]  sel_mask;

  cheshire_cfg_seq_filter #(
    .CfgIdxW      (CfgIdxW),
    .SyncStages   (SyncStages),
    .StableCycles (StableCycles)
  ) i_filter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .idx_i    (cfg_idx_i),
    .en_i     (state_q == SYNC),
    .clr_i    (state_q != SYNC),
    .stable_o (filt_stable),
    .idx_o    (filt_idx)
  );

  assign filt_oor = (32'(filt_idx) >= NumCfgs);
  assign idx_eff  = filt_oor ? CfgIdxW'(DefaultIdx) : filt_idx;
  assign mask_ext = MaxMaskW'(cfg_core_mask_i);
  assign sel_mask = cfg_mask_slice(mask_ext, 32'(idx_eff), NumCores);

`ifdef CHESHIRE_CFG_SEQ_LOCK_EN
  logic lock_d, lock_q;
  // Lock is sticky once requested in RUN; only the hard reset clears it.
  always_comb lock_d = lock_q | ((state_q == RUN) & lock_i);
  // Lock register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_q <= 1'b0;
    else         lock_q <= lock_d;
  end
  assign locked = lock_q;
`else
  logic lock_unused;
  assign lock_unused = lock_i;
  assign locked      = 1'b0;
`endif

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SYNC;
      ptr_q   <= '0;
      tmr_q   <= '0;
      mask_q  <= '0;
      rel_q   <= '0;
      idx_q   <= CfgIdxW'(DefaultIdx);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tmr_q   <= tmr_d;
      mask_q  <= mask_d;
      rel_q   <= rel_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: filter, latch, stagger releases, run, drain.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tmr_d   = tmr_q;
    mask_d  = mask_q;
    rel_d   = rel_q;
    idx_d   = idx_q;
    err_d   = err_q;
    unique case (state_q)
      SYNC: if (filt_stable) state_d = LATCH;
      LATCH: begin
        idx_d   = idx_eff;
        err_d   = filt_oor;
        mask_d  = sel_mask[NumCores-1:0];
        ptr_d   = '0;
        tmr_d   = '0;
        state_d = STAGGER;
      end
      STAGGER: begin
        // Enabled cores wait out the full stagger; disabled ones skip in one cycle.
        if (mask_q[ptr_q] && (tmr_q != TmrW'(StaggerCycles - 1))) begin
          tmr_d = tmr_q + 1'b1;
        end else begin
          tmr_d = '0;
          if (mask_q[ptr_q]) rel_d[ptr_q] = 1'b1;
          if (ptr_q == PtrW'(NumCores - 1)) state_d = RUN;
          else                              ptr_d   = ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (restart_req_i && !locked) begin
          rel_d   = '0;
          err_d   = 1'b0;
          tmr_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tmr_q == TmrW'(StaggerCycles - 1)) begin
          tmr_d   = '0;
          state_d = SYNC;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State-decoded outputs; ack marks the first DRAIN cycle.
  always_comb begin
    done_o        = (state_q == RUN);
    cfg_valid_o   = (state_q == STAGGER) || (state_q == RUN);
    restart_ack_o = (state_q == DRAIN) && (tmr_q == '0);
  end

  assign core_rst_no = rel_q;
  assign cfg_idx_o   = idx_q;
  assign cfg_err_o   = err_q;

endmodule

// File: doc/cheshire_cfg_sequencer.md
Name: cheshire_cfg_sequencer

Overview:
- Runtime successor to the static per-index SoC configuration table.
- Samples external config-select pins after reset and filters them until stable; out-of-range indices fall back to a default.
- Releases per-core resets in a staggered sequence according to a per-config core mask.
- Supports a handshaked soft restart that drains all cores and re-samples the pins.

Parameters:
- NumCfgs, 5, number of selectable configurations (>=2).
- NumCores, 4, number of core reset channels (1..16).
- CfgIdxW, $clog2(NumCfgs), width of config index (derived; do not override).
- SyncStages, 2, synchronizer flops on cfg_idx_i (>=2).
- StableCycles, 8, consecutive equal synchronized samples required before latching (>=1).
- StaggerCycles, 16, cycles between successive core reset releases; also drain time (>=1).
- DefaultIdx, 0, fallback index when the sampled index is >= NumCfgs.

Ports:
- clk_i, in, 1, single clock.
- rst_ni, in, 1, asynchronous active-low reset.
- cfg_idx_i, in, CfgIdxW, asynchronous config-select pins.
- cfg_core_mask_i, in, NumCfgs*NumCores, per-config active-core mask; quasi-static; slice k is cfg k.
- restart_req_i, in, 1, soft restart request (level; held until ack).
- restart_ack_o, out, 1, one-cycle ack pulse when drain starts.
- lock_i, in, 1, lock request (only used with the optional feature).
- cfg_idx_o, out, CfgIdxW, latched effective config index.
- cfg_valid_o, out, 1, cfg_idx_o is valid (high from LATCH through RUN).
- cfg_err_o, out, 1, sticky: latched index was out of range and DefaultIdx was used; cleared on restart.
- core_rst_no, out, NumCores, per-core active-low reset.
- done_o, out, 1, sequencing complete (RUN state).

Behaviour:
- Reset values: cfg_idx_o=DefaultIdx, cfg_valid_o=0, cfg_err_o=0, core_rst_no='0 (all cores held in reset), done_o=0, restart_ack_o=0, synchronizer flops 0.
- FSM states: SYNC, LATCH, STAGGER, RUN, DRAIN.
- SYNC: compare the synchronized index with the previous sample. Equal: increment the stable counter, saturating at StableCycles. Not equal: reset the counter to 1. When the counter reaches StableCycles, go to LATCH.
- LATCH (1 cycle):
  - Register the index. If >= NumCfgs, use DefaultIdx and set cfg_err_o.
  - Capture that config's mask slice into an internal mask register (later mask input changes are ignored).
  - cfg_valid_o rises the next cycle. Go to STAGGER with core pointer=0 and timer=0.
- STAGGER: cores are handled in ascending index order.
  - Pointed core's mask bit=1: release that core when timer==StaggerCycles-1, then reset the timer and advance the pointer.
  - Mask bit=0: skip in 1 cycle without releasing.
  - After the pointer passes NumCores-1, go to RUN.
  - Mask all-zero: STAGGER lasts NumCores cycles and no core is released.
- RUN: done_o=1. Released cores stay released. If restart_req_i=1, go to DRAIN.
- DRAIN:
  - On entry cycle: restart_ack_o=1 for that one cycle; all core_rst_no=0; done_o=0; cfg_valid_o=0; cfg_err_o cleared.
  - Wait StaggerCycles cycles, then go to SYNC with the stable counter cleared.
- restart_req_i is ignored in all states except RUN.
- Latency: from rst_ni deassertion with stable pins to first core release = SyncStages+StableCycles+1+StaggerCycles cycles (+/-1, fixed by implementation; the bench measures against the exact RTL figure documented in the header).
- Stagger timer and stable counter are clog2(max+1) wide and never wrap.
- Asynchronous reset at any time, including mid-STAGGER or DRAIN, returns everything to reset values immediately.

Optional Feature:
- Macro: CHESHIRE_CFG_SEQ_LOCK_EN.
- Defined:
  - lock_i=1 sampled in RUN sets a sticky lock bit, cleared only by rst_ni.
  - While locked, restart_req_i is ignored; no ack and no drain.
- Undefined: lock_i is unused; restart is always honoured in RUN.

Decomposition:
- Package cheshire_cfg_seq_pkg:
  - State enum seq_state_e.
  - Helper function cfg_mask_slice(mask_vec, idx).
  - Default constants for StableCycles and StaggerCycles.
- Sub-module cheshire_cfg_seq_filter: synchronizer plus stability counter; outputs stable_o and idx_o. The FSM stays in the top module.

Test Plan:
- Reset release, cfg_idx_i=3, mask3=4'b1111 -> cores 0..3 released in order, 16 cycles apart; done_o=1 after the 4th; cfg_idx_o=3, cfg_err_o=0.
- cfg_idx_i=7 (out of range) -> cfg_idx_o=0, cfg_err_o=1, mask0 sequence applied.
- Pins toggle every 5 cycles, then settle at 2 -> no LATCH until 8 stable samples; latched index=2.
- Mask=4'b0101 -> only cores 0 and 2 released; cores 1 and 3 held low; skips take 1 cycle each.
- In RUN, assert restart_req_i, change pins to 1 -> one-cycle ack, all resets low for 16 cycles, re-sequence with cfg 1.
- rst_ni pulsed mid-STAGGER after 2 releases -> all core_rst_no=0 immediately; full sequence restarts. With LOCK_EN: lock then restart -> no ack, cores stay up.
